btn_debounce_flap: RTL and testbench

BTN_DEBOUNCE_FLAP -- requirements
Module: btn_debounce_flap

---
 rtl/btn_debounce_flap.sv | 121 ++++++++++++
 tb/tb_btn_debounce_flap.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/btn_debounce_flap.sv
// Two-button debouncer for the flap game: 2-flop synchronizer plus one
// IDLE/WAIT_HI/HELD/WAIT_LO FSM per button, with registered level and press tick.
// Optional build macro BTN_AUTOREPEAT_EN adds a per-button auto-repeat tick while held.
module btn_debounce_flap #(
  parameter int unsigned DB_CYCLES     = 2000000,
  parameter int unsigned REPEAT_CYCLES = 25000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_db,
  output logic [1:0] btn_tick
);

  typedef enum logic [1:0] {StIdle, StWaitHi, StHeld, StWaitLo} state_e;

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DB_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0] sync_q;
  logic [1:0] btn_s;

  // Bring the asynchronous buttons into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
      btn_s  <= 2'b00;
    end else begin
      sync_q <= btn_raw;
      btn_s  <= sync_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bit
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             tick_q;
`ifdef BTN_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_q;
`endif

    // Debounce FSM; counter is cleared on every transition and compared before incrementing.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        tick_q  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rep_q   <= '0;
`endif
      end else begin
        tick_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (btn_s[i]) begin
              state_q <= StWaitHi;
              cnt_q   <= '0;
            end
          end
          StWaitHi: begin
            if (!btn_s[i]) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == DbLast) begin
              state_q <= StHeld;
              cnt_q   <= '0;
              db_q    <= 1'b1;
              tick_q  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rep_q   <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StHeld: begin
            if (!btn_s[i]) begin
              state_q <= StWaitLo;
              cnt_q   <= '0;
            end
`ifdef BTN_AUTOREPEAT_EN
            // Repeat count survives a release bounce so a held button keeps its cadence.
            else if (rep_q == RepLast) begin
              tick_q <= 1'b1;
              rep_q  <= '0;
            end else begin
              rep_q <= rep_q + 1'b1;
            end
`endif
          end
          StWaitLo: begin
            if (btn_s[i]) begin
              state_q <= StHeld;
              cnt_q   <= '0;
            end else if (cnt_q == DbLast) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              db_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            db_q    <= 1'b0;
          end
        endcase
      end
    end

    assign btn_db[i]   = db_q;
    assign btn_tick[i] = tick_q;
  end

endmodule

// File: tb/tb_btn_debounce_flap.sv
// Scoreboard bench for btn_debounce_flap with DB_CYCLES=4, REPEAT_CYCLES=8.
// Expected {btn_db, btn_tick} is queued when each input is driven and checked after the edge.
module tb_btn_debounce_flap;

  localparam int unsigned DbCycles  = 4;
  localparam int unsigned RepCycles = 8;
  localparam int unsigned Lat       = DbCycles + 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AutoRep = 1'b1;
`else
  localparam bit AutoRep = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_db;
  logic [1:0] btn_tick;

  typedef struct {
    string      tag;
    logic [3:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;

  btn_debounce_flap #(
    .DB_CYCLES    (DbCycles),
    .REPEAT_CYCLES(RepCycles),
    .CNT_W        (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_raw),
    .btn_db  (btn_db),
    .btn_tick(btn_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got db/tick=%b/%b want %b/%b @%0t",
               tag, got[3:2], got[1:0], exp[3:2], exp[1:0], $time);
    end
  endtask

  // Pop one expectation per edge, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.tag, {btn_db, btn_tick}, e.val);
    end
  end

  task automatic cyc(input logic [1:0] raw, input logic [1:0] edb, input logic [1:0] etk,
                     input string tag);
    exp_t e;
    @(negedge clk);
    btn_raw = raw;
    e.tag = tag;
    e.val = {edb, etk};
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Press mask m for h edges, then release; edge e counts from the first driven edge.
  task automatic press(input logic [1:0] m, input int h, input string tag);
    for (int e = 1; e <= h + Lat + 1; e++) begin
      logic [1:0] raw, edb, etk;
      raw = (e <= h) ? m : 2'b00;
      edb = (e >= Lat && e <= h + Lat - 1) ? m : 2'b00;
      etk = (e == Lat || (AutoRep && e > Lat && e <= h + 2 &&
             ((e - Lat) % RepCycles) == 0)) ? m : 2'b00;
      cyc(raw, edb, etk, tag);
    end
    for (int k = 0; k < 3; k++) cyc(2'b00, 2'b00, 2'b00, {tag, "_idle"});
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    btn_raw = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {btn_db, btn_tick}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Clean press and release on each bit, then both together.
    press(2'b01, 10, "press0");
    press(2'b10, 12, "press1");
    press(2'b11, 10, "press_both");

    // Two-cycle glitch is rejected.
    for (int e = 1; e <= 12; e++)
      cyc((e <= 2) ? 2'b01 : 2'b00, 2'b00, 2'b00, "glitch");

    // Release bounce: drop for two edges, come back, then really release.
    for (int e = 1; e <= 24; e++) begin
      logic [1:0] raw;
      raw = (e <= 10 || e == 13 || e == 14) ? 2'b01 : 2'b00;
      cyc(raw, (e >= Lat && e <= 20) ? 2'b01 : 2'b00, (e == Lat) ? 2'b01 : 2'b00, "bounce");
    end

    // Reset in WAIT_HI with the button held, then a fresh debounce.
    for (int e = 1; e <= 4; e++) cyc(2'b01, 2'b00, 2'b00, "rst_wh_pre");
    #3 reset = 1'b1;
    #1 check("rst_wh_async", {btn_db, btn_tick}, 4'b0000);
    @(posedge clk);
    #2 reset = 1'b0;
    press(2'b01, 10, "rst_wh_post");

    // Reset while held: level must drop at once.
    for (int e = 1; e <= 9; e++)
      cyc(2'b01, (e >= Lat) ? 2'b01 : 2'b00, (e == Lat) ? 2'b01 : 2'b00, "rst_hold_pre");
    #3 reset = 1'b1;
    #1 check("rst_hold_async", {btn_db, btn_tick}, 4'b0000);
    @(posedge clk);
    #2 reset = 1'b0;
    press(2'b01, 10, "rst_hold_post");

    // Long hold: repeat ticks only in the auto-repeat build.
    press(2'b01, 37, "long_hold");

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
